// File: rtl/spi_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_bridge_pkg
//  Description : Shared types and helpers for the SPI slave buffering bridge:
//                transfer FSM encoding, fill-mode constants, level width.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_bridge_pkg;

    // Transfer sequencing states, one per phase of a core transfer
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PRESENT = 2'd2,
        ACTIVE  = 2'd3
    } bridge_state_t;

    // Underrun fill-pattern selection (fill_mode input values)
    localparam logic FILL_ZERO  = 1'b0;
    localparam logic FILL_COUNT = 1'b1;

    // Occupancy counters need one extra bit to represent a completely full FIFO
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock first-word-fall-through FIFO with occupancy
//                output. Pointers carry an extra wrap bit so full and empty
//                are distinguished without a separate counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import spi_bridge_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            push,
    input  logic [WIDTH-1:0]                push_data,
    input  logic                            pop,
    output logic [WIDTH-1:0]                pop_data,
    output logic [level_width(DEPTH)-1:0]   level,
    output logic                            full,
    output logic                            empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only legal when the head leaves this cycle
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);

    assign level    = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (level == LW'(DEPTH));
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Pointer advance; reset empties the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/spi_slave_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_bridge
//  Description : Buffering bridge beside an SPI_Slave core. TX FIFO supplies
//                the next outgoing word at each transfer start, RX FIFO
//                captures received words, an underrun fill generator covers
//                an empty TX FIFO, and sticky flags drive an interrupt.
//                Optional macro SPI_BRIDGE_STATS_EN adds xfer_count and
//                drop_count statistics outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_bridge
    import spi_bridge_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int TX_DEPTH    = 16,
    parameter int RX_DEPTH    = 16,
    parameter int SYNC_STAGES = 2,
    parameter int RX_THRESH   = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              core_busy,
    input  logic                              core_rx_valid,
    input  logic [DATA_WIDTH-1:0]             core_rx_data,
    output logic                              core_tx_valid,
    output logic [DATA_WIDTH-1:0]             core_tx_data,
    input  logic                              tx_wr_valid,
    input  logic [DATA_WIDTH-1:0]             tx_wr_data,
    output logic                              tx_wr_ready,
    output logic                              rx_rd_valid,
    output logic [DATA_WIDTH-1:0]             rx_rd_data,
    input  logic                              rx_rd_ready,
    input  logic                              fill_mode,
    input  logic                              clear_flags,
    output logic [level_width(TX_DEPTH)-1:0]  tx_level,
    output logic [level_width(RX_DEPTH)-1:0]  rx_level,
    output logic                              underrun,
    output logic                              overrun,
`ifdef SPI_BRIDGE_STATS_EN
    output logic [15:0]                       xfer_count,
    output logic [15:0]                       drop_count,
`endif
    output logic                              intr
);

    localparam int RX_LW = level_width(RX_DEPTH);
    localparam logic [RX_LW-1:0] RX_THRESH_LVL = RX_LW'(RX_THRESH);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   busy_q;
    logic                   busy_rise;
    logic                   busy_fall;

    bridge_state_t          state;
    logic                   fall_pending;
    logic [DATA_WIDTH-1:0]  fill_cnt;

    logic [DATA_WIDTH-1:0]  tx_head;
    logic                   tx_full;
    logic                   tx_empty;
    logic                   tx_pop;
    logic                   rx_full;
    logic                   rx_empty;
    logic                   rx_push;
    logic                   rx_pop;
    logic                   rx_drop;

    // Bring the asynchronous core busy into clk and keep one delayed copy for edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            busy_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], core_busy};
            busy_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign busy_rise = sync_q[SYNC_STAGES-1] & ~busy_q;
    assign busy_fall = ~sync_q[SYNC_STAGES-1] & busy_q;

    // TX: writes to a full FIFO are refused even if LOAD pops in the same cycle
    assign tx_wr_ready = ~tx_full;
    assign tx_pop      = (state == LOAD) & ~tx_empty;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_wr_valid & tx_wr_ready),
        .push_data (tx_wr_data),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .level     (tx_level),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    // RX: a full FIFO still accepts a word when the application pops the same cycle
    assign rx_rd_valid = ~rx_empty;
    assign rx_pop      = rx_rd_valid & rx_rd_ready;
    assign rx_push     = core_rx_valid & (~rx_full | rx_pop);
    assign rx_drop     = core_rx_valid & rx_full & ~rx_pop;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rx_push),
        .push_data (core_rx_data),
        .pop       (rx_pop),
        .pop_data  (rx_rd_data),
        .level     (rx_level),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    // Transfer sequencer: load next word, present it for one cycle, wait for busy to drop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            core_tx_valid <= 1'b0;
            core_tx_data  <= '0;
            fill_cnt      <= '0;
            fall_pending  <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            core_tx_valid <= 1'b0;
            if (clear_flags) underrun <= 1'b0;
            case (state)
                IDLE: begin
                    fall_pending <= 1'b0;
                    if (busy_rise) state <= LOAD;
                end
                LOAD: begin
                    if (!tx_empty) begin
                        core_tx_data <= tx_head;
                    end else begin
                        // Underrun set overrides a coincident clear
                        core_tx_data <= (fill_mode == FILL_COUNT) ? fill_cnt : '0;
                        fill_cnt     <= fill_cnt + DATA_WIDTH'(1);
                        underrun     <= 1'b1;
                    end
                    core_tx_valid <= 1'b1;
                    if (busy_fall) fall_pending <= 1'b1;
                    state <= PRESENT;
                end
                PRESENT: begin
                    if (busy_fall) fall_pending <= 1'b1;
                    state <= ACTIVE;
                end
                ACTIVE: begin
                    if (busy_fall || fall_pending) begin
                        fall_pending <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky overrun and the registered interrupt (lags its sources by one cycle)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
            intr    <= 1'b0;
        end else begin
            if (rx_drop)          overrun <= 1'b1;
            else if (clear_flags) overrun <= 1'b0;
            intr <= (rx_level >= RX_THRESH_LVL) | overrun | underrun;
        end
    end

`ifdef SPI_BRIDGE_STATS_EN
    // Transfer counter wraps, drop counter saturates; both cleared with the flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count <= '0;
            drop_count <= '0;
        end else if (clear_flags) begin
            xfer_count <= '0;
            drop_count <= '0;
        end else begin
            if (busy_rise) xfer_count <= xfer_count + 16'd1;
            if (rx_drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave_bridge
//  Description : Self-checking bench for spi_slave_bridge. Queue-based
//                reference model of the TX/RX FIFOs, fill generator and
//                sticky flags; a monitor scores core_tx and RX pops.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_bridge;

    localparam int DW  = 8;
    localparam int TXD = 16;
    localparam int RXD = 16;
    localparam int SS  = 2;
    localparam int TH  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          core_busy;
    logic          core_rx_valid;
    logic [DW-1:0] core_rx_data;
    logic          core_tx_valid;
    logic [DW-1:0] core_tx_data;
    logic          tx_wr_valid;
    logic [DW-1:0] tx_wr_data;
    logic          tx_wr_ready;
    logic          rx_rd_valid;
    logic [DW-1:0] rx_rd_data;
    logic          rx_rd_ready;
    logic          fill_mode;
    logic          clear_flags;
    logic [4:0]    tx_level;
    logic [4:0]    rx_level;
    logic          underrun;
    logic          overrun;
    logic          intr;
`ifdef SPI_BRIDGE_STATS_EN
    logic [15:0]   xfer_count;
    logic [15:0]   drop_count;
`endif

    spi_slave_bridge #(
        .DATA_WIDTH  (DW),
        .TX_DEPTH    (TXD),
        .RX_DEPTH    (RXD),
        .SYNC_STAGES (SS),
        .RX_THRESH   (TH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .core_busy     (core_busy),
        .core_rx_valid (core_rx_valid),
        .core_rx_data  (core_rx_data),
        .core_tx_valid (core_tx_valid),
        .core_tx_data  (core_tx_data),
        .tx_wr_valid   (tx_wr_valid),
        .tx_wr_data    (tx_wr_data),
        .tx_wr_ready   (tx_wr_ready),
        .rx_rd_valid   (rx_rd_valid),
        .rx_rd_data    (rx_rd_data),
        .rx_rd_ready   (rx_rd_ready),
        .fill_mode     (fill_mode),
        .clear_flags   (clear_flags),
        .tx_level      (tx_level),
        .rx_level      (rx_level),
        .underrun      (underrun),
        .overrun       (overrun),
`ifdef SPI_BRIDGE_STATS_EN
        .xfer_count    (xfer_count),
        .drop_count    (drop_count),
`endif
        .intr          (intr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } txexp_t;

    // Reference model state
    logic [DW-1:0] txq [$];
    logic [DW-1:0] rxq [$];
    txexp_t        txexp [$];
    bit            ov_m;
    bit            un_m;
    logic [DW-1:0] fill_m;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: scores every presented TX word and every RX pop against the model queues
    always @(negedge clk) begin : monitor
        txexp_t e;
        if (rst_n) begin
            if (core_tx_valid) begin
                if (txexp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_valid_unexpected actual=%0h expected=none (cycle %0d)", core_tx_data, cyc);
                end else begin
                    e = txexp.pop_front();
                    chk("tx_data", core_tx_data, e.data);
                    chk("tx_latency", cyc, e.due);
                end
            end
            if (rx_rd_valid && rx_rd_ready) begin
                if (rxq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_pop_unexpected actual=%0h expected=none (cycle %0d)", rx_rd_data, cyc);
                end else begin
                    chk("rx_data", rx_rd_data, rxq.pop_front());
                end
            end
        end
    end

    // One clock of application/core stimulus plus the model's reaction to it
    task automatic drive(input bit rv, input logic [DW-1:0] rd, input bit rr,
                         input bit tw, input logic [DW-1:0] td, input bit clr);
        bit drop;
        @(posedge clk);
        #1;
        core_rx_valid = rv;
        core_rx_data  = rd;
        rx_rd_ready   = rr;
        tx_wr_valid   = tw;
        tx_wr_data    = td;
        clear_flags   = clr;
        drop = 1'b0;
        if (rv) begin
            if (rxq.size() < RXD || rr) rxq.push_back(rd);
            else drop = 1'b1;
        end
        if (tw && txq.size() < TXD) txq.push_back(td);
        if (drop)     ov_m = 1'b1;
        else if (clr) ov_m = 1'b0;
        if (clr) un_m = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic quiet_check(input string tag);
        idle();
        idle();
        @(negedge clk);
        chk({tag, "_tx_level"}, tx_level, txq.size());
        chk({tag, "_rx_level"}, rx_level, rxq.size());
        chk({tag, "_overrun"}, overrun, ov_m);
        chk({tag, "_underrun"}, underrun, un_m);
        chk({tag, "_intr"}, intr, (rxq.size() >= TH) || ov_m || un_m);
        chk({tag, "_rx_valid"}, rx_rd_valid, rxq.size() > 0);
        chk({tag, "_tx_ready"}, tx_wr_ready, txq.size() < TXD);
    endtask

    // One core transfer: the served word is the TX head, else the fill pattern
    task automatic xfer(input bit fm, input int act);
        txexp_t e;
        idle();
        fill_mode = fm;
        if (txq.size() > 0) begin
            e.data = txq.pop_front();
        end else begin
            e.data = fm ? fill_m : '0;
            fill_m = fill_m + 1'b1;
            un_m   = 1'b1;
        end
        e.due = cyc + SS + 2;
        txexp.push_back(e);
        core_busy = 1'b1;
        repeat (act) idle();
        @(posedge clk);
        #1;
        core_busy = 1'b0;
        repeat (SS + 5) idle();
        chk("tx_served", txexp.size(), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n         = 1'b0;
        core_busy     = 1'b0;
        core_rx_valid = 1'b0;
        core_rx_data  = '0;
        tx_wr_valid   = 1'b0;
        tx_wr_data    = '0;
        rx_rd_ready   = 1'b0;
        fill_mode     = 1'b0;
        clear_flags   = 1'b0;
        ov_m   = 1'b0;
        un_m   = 1'b0;
        fill_m = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_valid", core_tx_valid, 0);
        chk("rst_tx_data", core_tx_data, 0);
        chk("rst_tx_level", tx_level, 0);
        chk("rst_rx_level", rx_level, 0);
        chk("rst_flags", {underrun, overrun, intr}, 0);
        chk("rst_rx_valid", rx_rd_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Two queued words served in order
        drive(1'b0, '0, 1'b0, 1'b1, 8'hA1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1, 8'hB2, 1'b0);
        quiet_check("t1_loaded");
        chk("t1_level2", tx_level, 2);
        xfer(1'b0, 3);
        xfer(1'b0, 3);
        quiet_check("t1_done");

        // Underrun with counting fill
        xfer(1'b1, 3);
        xfer(1'b1, 2);
        xfer(1'b1, 4);
        quiet_check("t2_under");
        chk("t2_underrun_set", underrun, 1);
        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        quiet_check("t2_clear");

        // RX overfill then drain
        for (int i = 0; i < 17; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, '0, 1'b0);
        quiet_check("t3_full");
        chk("t3_level16", rx_level, 16);
        chk("t3_overrun", overrun, 1);
        for (int i = 0; i < 16; i++) drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        quiet_check("t3_drained");

        // Full RX with coincident push and pop
        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 16; i++) drive(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, '0, 1'b0);
        drive(1'b1, 8'h55, 1'b1, 1'b0, '0, 1'b0);
        quiet_check("t4_pushpop");
        chk("t4_level16", rx_level, 16);
        chk("t4_no_overrun", overrun, 0);
        for (int i = 0; i < 16; i++) drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        quiet_check("t4_drained");

        // Interrupt threshold timing
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, '0, 1'b0);
        quiet_check("t5_three");
        drive(1'b1, 8'h43, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        chk("t5_intr_c0", intr, 0);
        idle();
        @(negedge clk);
        chk("t5_level4", rx_level, 4);
        chk("t5_intr_c1", intr, 0);
        idle();
        @(negedge clk);
        chk("t5_intr_c2", intr, 1);
        drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        idle();
        @(negedge clk);
        chk("t5_level3", rx_level, 3);
        chk("t5_intr_lag", intr, 1);
        idle();
        @(negedge clk);
        chk("t5_intr_drop", intr, 0);
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        quiet_check("t5_drained");

        // Randomised mix of traffic, transfers and clears
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: repeat ($urandom_range(1, 6))
                       drive(1'b0, '0, 1'b0, 1'b1, 8'($urandom), 1'b0);
                1: repeat ($urandom_range(1, 12))
                       drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0,
                             1'b0, '0, 1'b0);
                2: xfer(1'($urandom_range(0, 1)), $urandom_range(1, 5));
                default: drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
            endcase
            quiet_check("rnd");
        end

        // Asynchronous reset mid-transfer
        while (rxq.size() > 0) drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        while (txq.size() > 0) xfer(1'b0, 2);
        drive(1'b0, '0, 1'b0, 1'b1, 8'h11, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1, 8'h22, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1, 8'h33, 1'b0);
        begin : rst_xfer
            txexp_t e;
            idle();
            e.data = txq.pop_front();
            e.due  = cyc + SS + 2;
            txexp.push_back(e);
            core_busy = 1'b1;
        end
        repeat (7) idle();
        chk("t7_served_first", txexp.size(), 0);
        #2;
        rst_n     = 1'b0;
        core_busy = 1'b0;
        #1;
        chk("t7_tx_valid", core_tx_valid, 0);
        chk("t7_tx_data", core_tx_data, 0);
        chk("t7_tx_level", tx_level, 0);
        chk("t7_rx_level", rx_level, 0);
        chk("t7_flags", {underrun, overrun, intr}, 0);
        txq.delete();
        rxq.delete();
        ov_m   = 1'b0;
        un_m   = 1'b0;
        fill_m = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        xfer(1'b0, 3);
        quiet_check("t7_after");

        chk("end_rx_model_empty", rxq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_slave_bridge.md
Name: spi_slave_bridge

Overview:
Parametrised buffering bridge between the SPI_Slave core and application logic. It replaces hand-wired counter/LED glue with a TX FIFO that feeds the core's next outgoing word, an RX FIFO that captures received words, an underrun fill-pattern generator and a level/flag interrupt. It sits directly beside SPI_Slave inside top-level designs and serves any word width.

Parameters:
DATA_WIDTH, 8, width of SPI words and FIFO entries
TX_DEPTH, 16, TX FIFO entries (power of two, >=2)
RX_DEPTH, 16, RX FIFO entries (power of two, >=2)
SYNC_STAGES, 2, synchroniser flops on core busy (>=2)
RX_THRESH, 1, RX level at or above which intr asserts (1..RX_DEPTH)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
core_busy  in  1  SPI_Slave busy (asynchronous to clk)
core_rx_valid  in  1  SPI_Slave data_out_valid, 1-cycle pulse
core_rx_data  in  DATA_WIDTH  SPI_Slave data_out
core_tx_valid  out  1  to SPI_Slave data_in_valid, 1-cycle pulse
core_tx_data  out  DATA_WIDTH  to SPI_Slave data_in
tx_wr_valid  in  1  app write request
tx_wr_data  in  DATA_WIDTH  app write word
tx_wr_ready  out  1  TX FIFO not full
rx_rd_valid  out  1  RX FIFO not empty
rx_rd_data  out  DATA_WIDTH  RX head word (valid while rx_rd_valid)
rx_rd_ready  in  1  app pop
fill_mode  in  1  0: fill with zeros, 1: fill with incrementing counter
clear_flags  in  1  clears sticky flags (1-cycle pulse)
tx_level  out  $clog2(TX_DEPTH)+1  TX occupancy
rx_level  out  $clog2(RX_DEPTH)+1  RX occupancy
underrun  out  1  sticky: transfer started with TX empty
overrun  out  1  sticky: RX word dropped, FIFO full
intr  out  1  registered interrupt

Behaviour:
- Reset (async, rst_n=0): FIFOs empty, levels 0, core_tx_valid=0, core_tx_data=0, fill counter=0, underrun=overrun=0, intr=0, FSM=IDLE, sync chain=0.
- core_busy passes through SYNC_STAGES flops; busy_rise = synced 0->1, busy_fall = 1->0.
- FSM: IDLE --busy_rise--> LOAD; LOAD (1 cycle) --> PRESENT; PRESENT (1 cycle) --> ACTIVE; ACTIVE --busy_fall--> IDLE.
- LOAD: if TX non-empty, pop head into core_tx_data; else core_tx_data = 0 (fill_mode=0) or fill counter (fill_mode=1), fill counter += 1 mod 2^DATA_WIDTH, underrun set.
- PRESENT: core_tx_valid=1 for exactly one cycle; core_tx_data holds until next LOAD.
- Latency: busy_rise cycle N -> core_tx_valid high at N+2.
- busy_rise while not IDLE is ignored; a busy_fall before ACTIVE is remembered and causes ACTIVE->IDLE on the next cycle.
- RX: core_rx_valid pushes core_rx_data if not full, or if full and rx pop occurs the same cycle; otherwise word dropped, overrun set.
- TX: write accepted when tx_wr_valid & tx_wr_ready; write to full is refused even with a same-cycle pop; same-cycle write+pop on non-full keeps level unchanged.
- rx_rd_data is first-word-fall-through; pop when rx_rd_valid & rx_rd_ready; pop on empty ignored.
- Sticky flags: a set in the same cycle as clear_flags wins (flag stays 1).
- intr registered: (rx_level >= RX_THRESH) | overrun | underrun, one-cycle lag.
- Levels use modular pointers with an extra wrap bit; full when level == DEPTH.

Optional Feature:
SPI_BRIDGE_STATS_EN: when defined, adds outputs xfer_count[15:0] (busy_rise count, wraps at 0xFFFF) and drop_count[15:0] (RX drops, saturates at 0xFFFF), both cleared by reset and clear_flags. When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package spi_bridge_pkg: FSM state enum (IDLE, LOAD, PRESENT, ACTIVE), FILL_ZERO/FILL_COUNT constants, a level-width function.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH; FWFT, level output), instantiated twice for TX and RX. The synchroniser and FSM stay inline.

Test Plan:
- Write 0xA1,0xB2 to TX, pulse core_busy twice -> core_tx_data 0xA1 then 0xB2, each core_tx_valid 1 cycle exactly 2 cycles after busy_rise, tx_level 2->0.
- TX empty, fill_mode=1, three transfers -> core_tx_data 0x00,0x01,0x02, underrun=1, intr=1; clear_flags -> underrun=0.
- 17 core_rx_valid pulses (0x00..0x10), no reads, RX_DEPTH=16 -> rx_level=16, overrun=1, reads return 0x00..0x0F.
- RX full, core_rx_valid and rx_rd_ready in the same cycle -> push accepted, level stays 16, overrun stays 0.
- rst_n low while in ACTIVE with 3 TX entries -> all outputs at reset values immediately; after release, busy_rise serves fill 0x00 and tx_level=0.
- RX_THRESH=4: push 3 words -> intr=0; 4th -> intr=1 next cycle; one pop -> intr=0.
